linked_list_sum_ctrl: RTL and testbench
=======================================

LINKED_LIST_SUM_CTRL -- requirements
Module: linked_list_sum_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8: width of the node counter.
REQ-002 SHALL have parameter MAX_NODES, default 255: node limit used by the watchdog (REQ-025).
REQ-003 SHALL have port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset, sampled on the Clk rising edge).
REQ-005 SHALL have port start, input, 1: request a list traversal; level-sampled.
REQ-006 SHALL have port next_zero, input, 1: datapath flag, 1 when the next-pointer register holds 0 (end of list).
REQ-007 SHALL have port a_sel, output, 1: datapath address source select; 0 = head pointer, 1 = next-pointer register.
REQ-008 SHALL have port next_sel, output, 1: next-register source select; 0 = load head pointer, 1 = load next field from memory.
REQ-009 SHALL have port sum_sel, output, 1: sum-register select; 0 = clear to 0, 1 = sum + memory data.
REQ-010 SHALL have port busy, output, 1: high in every non-IDLE state.
REQ-011 SHALL have port done, output, 1: one-cycle pulse on traversal completion.
REQ-012 SHALL have port node_count, output, CNT_WIDTH: number of nodes accumulated in the current or last traversal.
REQ-013 SHALL have port error, output, 1: watchdog tripped (REQ-025); tied 0 when the feature is compiled out.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, CLEAR, CHECK, ACCUM, DONE, plus ERROR when compiled in; all outputs decode from registered state or registered counters only.
REQ-015 IDLE SHALL drive a_sel=0, next_sel=0, sum_sel=0, busy=0, and go to CLEAR when start=1 is sampled.
REQ-016 CLEAR SHALL drive a_sel=0, next_sel=0, sum_sel=0 for exactly one cycle, clear node_count to 0, and go to CHECK.
REQ-017 CHECK SHALL drive a_sel=1, next_sel=0, sum_sel=1, with the datapath holding its registers; go to DONE if next_zero=1, else go to ACCUM.
REQ-018 ACCUM SHALL drive a_sel=1, next_sel=1, sum_sel=1 for one cycle, increment node_count, and go to CHECK.
REQ-019 DONE SHALL drive done=1 and busy=1 for one cycle, then go to IDLE; node_count SHALL hold its value until the next CLEAR.
REQ-020 Latency for a list of N nodes, with start sampled at edge k, SHALL be: done high during the cycle after edge k+2+2N.
REQ-021 An empty list (head = 0, next_zero=1 in the first CHECK) SHALL complete with node_count=0, done at edge k+3.
REQ-022 start SHALL be ignored while busy=1; if start is still high in IDLE after DONE, a new traversal SHALL begin.
REQ-023 node_count SHALL saturate at 2^CNT_WIDTH-1 and never wrap.

Reset
REQ-024 With reset=0 at a rising Clk edge, the block SHALL enter IDLE with node_count=0, done=0, error=0, busy=0, and all selects 0; this applies from any state, including mid-traversal; reset SHALL take priority over start.

Configuration
REQ-025 With macro LL_CTRL_NODE_LIMIT_EN defined, ACCUM SHALL go to ERROR instead of CHECK when the incremented node_count equals MAX_NODES. ERROR SHALL drive error=1, busy=1, and all selects 0, and SHALL return to IDLE only when start=0 is sampled (or on reset).
REQ-026 Without LL_CTRL_NODE_LIMIT_EN, the ERROR state and watchdog logic SHALL be absent, error SHALL be constant 0, and cyclic lists SHALL traverse indefinitely.

Verification
REQ-027 Reset: reset=0 for 2 cycles mid-ACCUM -> IDLE next edge; busy=0, node_count=0, selects 000.
REQ-028 Empty list: start=1 for one cycle, next_zero held 1 -> states CLEAR, CHECK, DONE; done pulses once; node_count=0.
REQ-029 Three-node list: next_zero=0 for 3 CHECKs, then 1 -> exactly 3 ACCUM cycles with selects 111; done 9 cycles after start; node_count=3.
REQ-030 start held high across DONE -> second traversal begins with CLEAR on the edge after IDLE; start pulses while busy have no effect.
REQ-031 Macro defined, MAX_NODES=4, next_zero stuck 0 -> error=1 after the 4th ACCUM; holds until start=0, then IDLE.
REQ-032 Macro undefined, CNT_WIDTH=2, next_zero stuck 0 for 6 ACCUMs -> node_count saturates at 3; error stays 0.

Source files
------------

// File: rtl/linked_list_sum_ctrl_if.sv
// Handshake and datapath-control bundle between the list-sum controller and its datapath.
`default_nettype none

interface linked_list_sum_ctrl_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 start;
    logic                 next_zero;
    logic                 a_sel;
    logic                 next_sel;
    logic                 sum_sel;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] node_count;
    logic                 error;

    // Requester/datapath side
    modport master (
        output start, next_zero,
        input  a_sel, next_sel, sum_sel, busy, done, node_count, error
    );

    // Controller side
    modport slave (
        input  start, next_zero,
        output a_sel, next_sel, sum_sel, busy, done, node_count, error
    );
endinterface

`default_nettype wire

// File: rtl/linked_list_sum_ctrl.sv
// Moore controller that walks a linked list and steers the sum datapath.
// Optional node-limit watchdog enabled by defining LL_CTRL_NODE_LIMIT_EN.
`default_nettype none

module linked_list_sum_ctrl #(
    parameter int CNT_WIDTH = 8,
    parameter int MAX_NODES = 255
) (
    input  logic                   Clk,
    input  logic                   reset,
    linked_list_sum_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_CHECK = 3'd2,
        ST_ACCUM = 3'd3,
`ifdef LL_CTRL_NODE_LIMIT_EN
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
`else
        ST_DONE  = 3'd4
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] node_count_q, node_count_d;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // A non-positive limit would never trip; the check keeps the parameter referenced in every build.
    if (MAX_NODES < 1) begin : g_max_nodes_unreachable
    end

    assign cnt_inc = (node_count_q == {CNT_WIDTH{1'b1}}) ? node_count_q
                                                         : node_count_q + CNT_WIDTH'(1);

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            node_count_q <= '0;
        end else begin
            state_q      <= state_d;
            node_count_q <= node_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        node_count_d = node_count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                node_count_d = '0;
                state_d      = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = bus.next_zero ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                node_count_d = cnt_inc;
`ifdef LL_CTRL_NODE_LIMIT_EN
                if (32'(cnt_inc) == 32'(MAX_NODES)) state_d = ST_ERROR;
                else                                state_d = ST_CHECK;
`else
                state_d = ST_CHECK;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
`ifdef LL_CTRL_NODE_LIMIT_EN
            ST_ERROR: begin
                // Stay latched until the requester drops start.
                if (!bus.start) state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.a_sel    = 1'b0;
        bus.next_sel = 1'b0;
        bus.sum_sel  = 1'b0;
        bus.busy     = (state_q != ST_IDLE);
        bus.done     = (state_q == ST_DONE);
        case (state_q)
            ST_CHECK: begin
                bus.a_sel   = 1'b1;
                bus.sum_sel = 1'b1;
            end
            ST_ACCUM: begin
                bus.a_sel    = 1'b1;
                bus.next_sel = 1'b1;
                bus.sum_sel  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.node_count = node_count_q;

`ifdef LL_CTRL_NODE_LIMIT_EN
    assign bus.error = (state_q == ST_ERROR);
`else
    assign bus.error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_linked_list_sum_ctrl.sv
// Directed bench for linked_list_sum_ctrl with immediate-assertion checks.
`default_nettype none

module tb_linked_list_sum_ctrl;

`ifdef LL_CTRL_NODE_LIMIT_EN
    localparam int TB_CNT = 8;
    localparam int TB_MAX = 4;
`else
    localparam int TB_CNT = 2;
    localparam int TB_MAX = 255;
`endif

    logic Clk;
    logic reset;
    int   checks;
    int   errors;
    int   accums;
    int   done_at;

    linked_list_sum_ctrl_if #(.CNT_WIDTH(TB_CNT)) bus ();

    linked_list_sum_ctrl #(
        .CNT_WIDTH (TB_CNT),
        .MAX_NODES (TB_MAX)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] sels();
        return {bus.a_sel, bus.next_sel, bus.sum_sel};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        bus.start     = 1'b0;
        bus.next_zero = 1'b1;
        reset         = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err",  32'(bus.error), 32'd0);
        check("rst_cnt",  32'(bus.node_count), 32'd0);
        check("rst_sel",  32'(sels()), 32'd0);

        // Empty list: CLEAR, CHECK, DONE
        reset     = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("empty_clr_busy", 32'(bus.busy), 32'd1);
        check("empty_clr_sel",  32'(sels()), 32'b000);
        tick();
        check("empty_chk_sel",  32'(sels()), 32'b101);
        check("empty_chk_done", 32'(bus.done), 32'd0);
        tick();
        check("empty_done",     32'(bus.done), 32'd1);
        check("empty_done_busy", 32'(bus.busy), 32'd1);
        check("empty_cnt",      32'(bus.node_count), 32'd0);
        tick();
        check("empty_idle_done", 32'(bus.done), 32'd0);
        check("empty_idle_busy", 32'(bus.busy), 32'd0);

        // Three-node list: done observed on the 9th sampled cycle counting the start edge
        bus.next_zero = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check("three_clr_sel", 32'(sels()), 32'b000);
        accums  = 0;
        done_at = 0;
        for (int c = 2; c <= 30 && done_at == 0; c++) begin
            tick();
            if (sels() == 3'b111) begin
                accums++;
                if (accums == 3) bus.next_zero = 1'b1;
            end
            if (bus.done) done_at = c;
        end
        check("three_accums",  32'(accums), 32'd3);
        check("three_latency", 32'(done_at), 32'd9);
        check("three_cnt",     32'(bus.node_count), 32'd3);
        tick();
        check("three_hold_cnt", 32'(bus.node_count), 32'd3);
        check("three_idle",     32'(bus.busy), 32'd0);

        // start held high across DONE retriggers from IDLE
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        check("b2b_done1", 32'(bus.done), 32'd1);
        tick();
        check("b2b_idle", 32'(bus.busy), 32'd0);
        tick();
        check("b2b_clr_busy", 32'(bus.busy), 32'd1);
        check("b2b_clr_sel",  32'(sels()), 32'b000);
        bus.start = 1'b0;
        tick();
        check("b2b_chk_sel", 32'(sels()), 32'b101);
        tick();
        check("b2b_done2", 32'(bus.done), 32'd1);
        tick();

        // Reset mid-ACCUM with start high: reset wins
        bus.next_zero = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre_rst_accum", 32'(sels()), 32'b111);
        reset     = 1'b0;
        bus.start = 1'b1;
        tick();
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_cnt",  32'(bus.node_count), 32'd0);
        check("midrst_sel",  32'(sels()), 32'b000);
        tick();
        check("midrst2_busy", 32'(bus.busy), 32'd0);
        check("midrst2_done", 32'(bus.done), 32'd0);
        reset     = 1'b1;
        bus.start = 1'b0;
        tick();
        check("postrst_idle", 32'(bus.busy), 32'd0);

`ifdef LL_CTRL_NODE_LIMIT_EN
        // Cyclic list trips the watchdog after the 4th ACCUM
        bus.next_zero = 1'b0;
        bus.start     = 1'b1;
        accums = 0;
        for (int c = 0; c < 40 && !bus.error; c++) begin
            tick();
            if (sels() == 3'b111) accums++;
        end
        check("wd_error",  32'(bus.error), 32'd1);
        check("wd_accums", 32'(accums), 32'd4);
        check("wd_cnt",    32'(bus.node_count), 32'd4);
        check("wd_busy",   32'(bus.busy), 32'd1);
        check("wd_sel",    32'(sels()), 32'b000);
        tick();
        tick();
        check("wd_hold", 32'(bus.error), 32'd1);
        bus.start = 1'b0;
        tick();
        check("wd_release_err",  32'(bus.error), 32'd0);
        check("wd_release_busy", 32'(bus.busy), 32'd0);
`else
        // Cyclic list with a 2-bit counter: saturate at 3, no error; start ignored while busy
        bus.next_zero = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("sat_chk_sel", 32'(sels()), 32'b101);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_start_ignored", 32'(sels()), 32'b111);
        accums = 1;
        for (int c = 0; c < 40 && accums < 6; c++) begin
            tick();
            if (sels() == 3'b111) accums++;
        end
        check("sat_accums", 32'(accums), 32'd6);
        tick();
        check("sat_cnt",  32'(bus.node_count), 32'd3);
        check("sat_err",  32'(bus.error), 32'd0);
        check("sat_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("sat_rst_cnt", 32'(bus.node_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
